div_rem_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider for the RV32M ops DIV, DIVU, REM and REMU.
- Sits beside the single-cycle ALU in the execute stage and consumes the ALU operand muxes.
- Performs one unsigned "partial remainder < divisor" decision per iteration, using the same unsigned less-than comparator as the ALU (comparator_lt, sel_signed=0).
- Returns one registered 32-bit result per accepted request through a start/busy/valid handshake.

---
 rtl/div_rem_unit.sv | 187 ++++++++++++++++++
 tb/tb_div_rem_unit.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/div_rem_unit.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU behind a start/busy/valid handshake.
// Define DIV_FAST_SPECIAL_EN to resolve divide-by-zero and signed overflow in one cycle, skipping the iterations.

module comparator_lt #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sel_signed,
  output logic         o_lt
);
  assign o_lt = i_sel_signed ? ($signed(i_a) < $signed(i_b)) : (i_a < i_b);
endmodule

module div_rem_unit #(
  parameter int N = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [1:0]   i_op,
  input  logic [N-1:0] i_rs1,
  input  logic [N-1:0] i_rs2,
  input  logic         i_flush,
  output logic         o_busy,
  output logic         o_valid,
  output logic [N-1:0] o_result
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [N-1:0]  r_rem;
  logic [N-1:0]  r_dvd;
  logic [N-1:0]  r_dvs;
  logic [N-1:0]  r_quo;
  logic [N-1:0]  r_rs1;
  logic [1:0]    r_op;
  logic          r_qsign;
  logic          r_rsign;
  logic          r_div0;
  logic          r_ovf;
  logic          r_valid;
  logic [N-1:0]  r_result;

  logic          w_signed_in;
  logic          w_accept;
  logic          w_div0_in;
  logic          w_ovf_in;
  logic [N-1:0]  w_abs1;
  logic [N-1:0]  w_abs2;
  logic [N:0]    w_rem_sh;
  logic          w_lt;
  logic [N-1:0]  w_sub;
  logic          w_last;
  logic          w_op_signed;
  logic          w_op_rem;
  logic [N-1:0]  w_quo_fix;
  logic [N-1:0]  w_rem_fix;
  logic [N-1:0]  w_result;

  assign w_signed_in = ~i_op[0];
  assign w_accept    = (r_state == IDLE) && i_start && !i_flush;
  assign w_div0_in   = (i_rs2 == '0);
  assign w_ovf_in    = w_signed_in && (i_rs1 == MIN_NEG) && (i_rs2 == '1);
  assign w_abs1      = (w_signed_in && i_rs1[N-1]) ? -i_rs1 : i_rs1;
  assign w_abs2      = (w_signed_in && i_rs2[N-1]) ? -i_rs2 : i_rs2;

  // One restoring step: the remainder is always below the divisor, so the low N bits of the difference suffice.
  assign w_rem_sh = {r_rem, r_dvd[N-1]};

  comparator_lt #(.W(N + 1)) u_lt (
    .i_a          (w_rem_sh),
    .i_b          ({1'b0, r_dvs}),
    .i_sel_signed (1'b0),
    .o_lt         (w_lt)
  );

  assign w_sub  = w_rem_sh[N-1:0] - r_dvs;
  assign w_last = (r_cnt == CW'(N - 1));

  assign w_op_signed = ~r_op[0];
  assign w_op_rem    = r_op[1];
  assign w_quo_fix   = (w_op_signed && r_qsign) ? -r_quo : r_quo;
  assign w_rem_fix   = (w_op_signed && r_rsign) ? -r_rem : r_rem;

  always_comb begin
    w_result = w_op_rem ? w_rem_fix : w_quo_fix;
    if (r_div0) begin
      w_result = w_op_rem ? r_rs1 : '1;
    end else if (r_ovf) begin
      w_result = w_op_rem ? '0 : MIN_NEG;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
`ifdef DIV_FAST_SPECIAL_EN
          w_state_next = (w_div0_in || w_ovf_in) ? DONE : CALC;
`else
          w_state_next = CALC;
`endif
        end
      end
      CALC: begin
        if (i_flush) begin
          w_state_next = IDLE;
        end else if (w_last) begin
          w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dvd    <= '0;
      r_dvs    <= '0;
      r_quo    <= '0;
      r_rs1    <= '0;
      r_op     <= '0;
      r_qsign  <= 1'b0;
      r_rsign  <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_valid  <= 1'b0;
      r_result <= '0;
    end else begin
      r_valid <= (r_state == DONE) && !i_flush;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_op    <= i_op;
            r_dvd   <= w_abs1;
            r_dvs   <= w_abs2;
            r_rs1   <= i_rs1;
            r_qsign <= i_rs1[N-1] ^ i_rs2[N-1];
            r_rsign <= i_rs1[N-1];
            r_div0  <= w_div0_in;
            r_ovf   <= w_ovf_in;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
          end
        end
        CALC: begin
          if (!i_flush) begin
            r_rem <= w_lt ? w_rem_sh[N-1:0] : w_sub;
            r_quo <= {r_quo[N-2:0], ~w_lt};
            r_dvd <= {r_dvd[N-2:0], 1'b0};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (!i_flush) begin
            r_result <= w_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_busy   = (r_state != IDLE);
  assign o_valid  = r_valid;
  assign o_result = r_result;

endmodule

// File: tb/tb_div_rem_unit.sv
// Scoreboard bench for div_rem_unit: directed vectors push expected result and latency; a monitor checks each o_valid.
module tb_div_rem_unit;
  localparam int LAT = 33;
`ifdef DIV_FAST_SPECIAL_EN
  localparam int SPL = 1;
`else
  localparam int SPL = 33;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        busy;
  logic        valid;
  logic [31:0] result;

  typedef struct {
    logic [31:0] exp;
    int          acc;
    int          lat;
    int          id;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_txn = 0;

  div_rem_unit #(.N(32)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_start  (start),
    .i_op     (op),
    .i_rs1    (rs1),
    .i_rs2    (rs2),
    .i_flush  (flush),
    .o_busy   (busy),
    .o_valid  (valid),
    .o_result (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_valid: got result %h, expected no output", result);
      end else begin
        mon_e = sb.pop_front();
        check("result", result, mon_e.exp);
        check("latency", 32'(cyc - mon_e.acc), 32'(mon_e.lat));
        $display("txn %0d: result=%h expected=%h latency=%0d", mon_e.id, result, mon_e.exp, cyc - mon_e.acc);
      end
    end
  end

  // Call just after a negedge; returns 1 time unit after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit push);
    op    = o;
    rs1   = a;
    rs2   = b;
    start = 1'b1;
    if (push) begin
      sb.push_back('{exp, cyc + 1, lat, n_txn});
      n_txn++;
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drain(input int maxc);
    for (int i = 0; i < maxc && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d pending results, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat);
    issue(o, a, b, exp, lat, 1'b1);
    drain(60);
  endtask

  initial begin
    #3;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(valid), 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;

    // op: 0 DIV, 1 DIVU, 2 REM, 3 REMU
    run(2'd1, 32'd100,        32'd7,        32'd14,       LAT);
    run(2'd3, 32'd100,        32'd7,        32'd2,        LAT);
    run(2'd0, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFD, LAT);
    run(2'd2, 32'hFFFFFFF9,   32'd2,        32'hFFFFFFFF, LAT);
    run(2'd0, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD, LAT);
    run(2'd2, 32'd7,          32'hFFFFFFFE, 32'd1,        LAT);
    run(2'd0, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'd3,        LAT);
    run(2'd2, 32'hFFFFFFF9,   32'hFFFFFFFE, 32'hFFFFFFFF, LAT);
    run(2'd0, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, SPL);
    run(2'd2, 32'h80000000,   32'hFFFFFFFF, 32'd0,        SPL);
    run(2'd0, 32'd5,          32'd0,        32'hFFFFFFFF, SPL);
    run(2'd3, 32'd5,          32'd0,        32'd5,        SPL);
    run(2'd2, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFB, SPL);
    run(2'd0, 32'hFFFFFFFB,   32'd0,        32'hFFFFFFFF, SPL);
    run(2'd1, 32'h80000000,   32'hFFFFFFFF, 32'd0,        LAT);
    run(2'd3, 32'h80000000,   32'hFFFFFFFF, 32'h80000000, LAT);
    run(2'd1, 32'hFFFFFFFF,   32'd1,        32'hFFFFFFFF, LAT);
    run(2'd0, 32'h80000000,   32'd1,        32'h80000000, LAT);

    // Start while busy is ignored; start in the o_valid cycle is accepted.
    issue(2'd1, 32'd100, 32'd7, 32'd14, LAT, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    check("busy_in_calc", 32'(busy), 32'd1);
    issue(2'd3, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      #1;
      if (valid) break;
    end
    check("valid_seen", 32'(valid), 32'd1);
    issue(2'd0, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, LAT, 1'b1);
    drain(60);

    // Flush mid-CALC: back to idle, no result, o_result retained.
    issue(2'd1, 32'd1000, 32'd10, 32'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_valid", 32'(valid), 32'd0);
    check("flush_result_hold", result, 32'hFFFFFFFD);
    repeat (45) @(negedge clk);
    #1;

    // Asynchronous reset mid-CALC clears outputs without a clock edge.
    issue(2'd1, 32'd1000, 32'd10, 32'd0, 0, 1'b0);
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_valid", 32'(valid), 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    #1;
    run(2'd1, 32'd1000, 32'd10, 32'd100, LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
